// File: rtl/man_jump_ctrl_pkg.sv
// Shared game constants and the man-sprite FSM state encoding.
// The graphics side imports the same screen and ground constants.
package man_jump_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHARGE = 2'd1,
        ST_FLIGHT = 2'd2
    } state_t;

    localparam int          SCREEN_W   = 640;
    localparam logic [9:0]  X_MAX      = 10'(SCREEN_W - 1);
    localparam logic [9:0]  X_START    = 10'd40;
    localparam logic [9:0]  Y_GROUND   = 10'd400;
    localparam logic [5:0]  CHARGE_MAX = 6'd63;
    localparam logic [2:0]  DIST_GAIN  = 3'd4;
    localparam int          LOG_T      = 5;
    localparam int          HSHIFT     = 2;
    localparam logic [5:0]  T_FLIGHT   = 6'(1 << LOG_T);

    // Squeeze shown while charging: a quarter of the charge, capped at 15.
    function automatic logic [3:0] squeeze_of(input logic [5:0] charge);
        logic [5:0] s;
        s = charge >> 2;
        return (s > 6'd15) ? 4'd15 : s[3:0];
    endfunction

endpackage

// File: rtl/man_jump_ctrl_jump_traj.sv
// Combinational jump trajectory: x advances linearly with t and is clamped
// to the right screen edge, y follows an upside-down parabola above ground.
module jump_traj
    import man_jump_ctrl_pkg::*;
(
    input  logic [9:0] i_x0,
    input  logic [9:0] i_dist,
    input  logic [5:0] i_t,
    output logic [9:0] o_x,
    output logic [9:0] o_y
);

    logic [15:0] w_dx_prod;
    logic [15:0] w_x_sum;
    logic [15:0] w_h_prod;
    logic [15:0] w_h;

    assign w_dx_prod = 16'(i_dist) * 16'(i_t);
    assign w_x_sum   = 16'(i_x0) + (w_dx_prod >> LOG_T);
    assign w_h_prod  = 16'(i_t) * (16'(T_FLIGHT) - 16'(i_t));
    assign w_h       = w_h_prod >> HSHIFT;

    // Clamp x at the screen edge and lift y by the parabola height.
    always_comb begin
        o_x = (w_x_sum > 16'(X_MAX)) ? X_MAX : 10'(w_x_sum);
        o_y = 10'(16'(Y_GROUND) - w_h);
    end

endmodule

// File: rtl/man_jump_ctrl.sv
// Man sprite controller: button charge -> squeeze level, release -> parabolic
// jump advanced once per frame tick, one-cycle landing pulse at the end.
module man_jump_ctrl
    import man_jump_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_en,
    input  logic       i_press,
    input  logic       i_reset_pos,
    output logic [9:0] o_x_man,
    output logic [9:0] o_y_man,
    output logic [3:0] o_squeeze_man,
    output logic       o_busy,
    output logic       o_landed,
    output logic [9:0] o_jump_dist
);

    state_t      r_state, w_state_next;
    logic [5:0]  r_charge, w_charge_next;
    logic [5:0]  r_t, w_t_next;
    logic [9:0]  r_x0, w_x0_next;
    logic [9:0]  r_x, w_x_next;
    logic [9:0]  r_y, w_y_next;
    logic [3:0]  r_sq, w_sq_next;
    logic        r_busy, w_busy_next;
    logic        r_landed, w_landed_next;
    logic [9:0]  r_jdist, w_jdist_next;
    logic        r_armed, w_armed_next;
    logic        r_press_prev;

    logic        w_rise;
    logic [5:0]  w_t_inc;
    logic [5:0]  w_charge_inc;
    logic [12:0] w_dist_full;
    logic [9:0]  w_dist_sat;
    logic [9:0]  w_traj_x;
    logic [9:0]  w_traj_y;

    assign w_rise       = i_press & ~r_press_prev;
    assign w_t_inc      = r_t + 6'd1;
    assign w_charge_inc = (r_charge == CHARGE_MAX) ? CHARGE_MAX : r_charge + 6'd1;
    assign w_dist_full  = 13'(r_charge) * 13'(DIST_GAIN);
    assign w_dist_sat   = (w_dist_full > 13'd1023) ? 10'd1023 : w_dist_full[9:0];

    // Position for the tick about to be taken (t + 1).
    jump_traj u_traj (
        .i_x0   (r_x0),
        .i_dist (r_jdist),
        .i_t    (w_t_inc),
        .o_x    (w_traj_x),
        .o_y    (w_traj_y)
    );

    // Next-state and next-output logic; disable overrides everything.
    always_comb begin
        w_state_next  = r_state;
        w_charge_next = r_charge;
        w_t_next      = r_t;
        w_x0_next     = r_x0;
        w_x_next      = r_x;
        w_y_next      = r_y;
        w_sq_next     = r_sq;
        w_landed_next = 1'b0;
        w_jdist_next  = r_jdist;
        w_armed_next  = r_armed;

        if (!i_en) begin
            w_state_next  = ST_IDLE;
            w_charge_next = 6'd0;
            w_t_next      = 6'd0;
            w_sq_next     = 4'd0;
            w_y_next      = Y_GROUND;
            w_armed_next  = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (!i_press) w_armed_next = 1'b1;
                    if (i_reset_pos) w_x_next = X_START;
                    if (w_rise && r_armed) begin
                        w_state_next  = ST_CHARGE;
                        w_charge_next = 6'd0;
                        w_sq_next     = 4'd0;
                    end
                end
                ST_CHARGE: begin
                    // Release beats a coincident tick.
                    if (!i_press) begin
                        w_sq_next = 4'd0;
                        if (r_charge != 6'd0) begin
                            w_state_next = ST_FLIGHT;
                            w_jdist_next = w_dist_sat;
                            w_x0_next    = r_x;
                            w_t_next     = 6'd0;
                            w_armed_next = 1'b0;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else if (i_tick) begin
                        w_charge_next = w_charge_inc;
                        w_sq_next     = squeeze_of(w_charge_inc);
                    end
                end
                ST_FLIGHT: begin
                    if (i_tick) begin
                        w_t_next = w_t_inc;
                        w_x_next = w_traj_x;
                        w_y_next = w_traj_y;
                        if (w_t_inc == T_FLIGHT) begin
                            w_state_next  = ST_IDLE;
                            w_landed_next = 1'b1;
                            w_t_next      = 6'd0;
                        end
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end

        w_busy_next = (w_state_next != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_charge     <= 6'd0;
            r_t          <= 6'd0;
            r_x0         <= X_START;
            r_x          <= X_START;
            r_y          <= Y_GROUND;
            r_sq         <= 4'd0;
            r_busy       <= 1'b0;
            r_landed     <= 1'b0;
            r_jdist      <= 10'd0;
            r_armed      <= 1'b1;
            r_press_prev <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_charge     <= w_charge_next;
            r_t          <= w_t_next;
            r_x0         <= w_x0_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_sq         <= w_sq_next;
            r_busy       <= w_busy_next;
            r_landed     <= w_landed_next;
            r_jdist      <= w_jdist_next;
            r_armed      <= w_armed_next;
            r_press_prev <= i_press;
        end
    end

    assign o_x_man       = r_x;
    assign o_y_man       = r_y;
    assign o_squeeze_man = r_sq;
    assign o_busy        = r_busy;
    assign o_landed      = r_landed;
    assign o_jump_dist   = r_jdist;

endmodule

// File: tb/tb_man_jump_ctrl.sv
// Directed bench for man_jump_ctrl: a vector table of input phases with
// hand-computed expected outputs, plus hand sequences for the multi-cycle
// corners (saturated flight, coincident release/tick, async reset).
module tb_man_jump_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_tick, i_en, i_press, i_reset_pos;
    logic [9:0] o_x_man, o_y_man, o_jump_dist;
    logic [3:0] o_squeeze_man;
    logic       o_busy, o_landed;

    int checks   = 0;
    int failures = 0;

    man_jump_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tick        (i_tick),
        .i_en          (i_en),
        .i_press       (i_press),
        .i_reset_pos   (i_reset_pos),
        .o_x_man       (o_x_man),
        .o_y_man       (o_y_man),
        .o_squeeze_man (o_squeeze_man),
        .o_busy        (o_busy),
        .o_landed      (o_landed),
        .o_jump_dist   (o_jump_dist)
    );

    always #5 clk = ~clk;

    // One row: hold press/en, pulse reset_pos in the first (tick-free) cycle,
    // then give 'ticks' tick cycles, then compare.
    typedef struct {
        logic       press;
        logic       en;
        logic       rpos;
        int         ticks;
        logic [9:0] ex;
        logic [9:0] ey;
        logic [3:0] esq;
        logic       ebusy;
        logic       eland;
        logic [9:0] edist;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic p, input logic e, input logic r, input int t,
                                input int x, input int y, input int sq, input logic b,
                                input logic l, input int d);
        vec_t v;
        v.press = p; v.en = e; v.rpos = r; v.ticks = t;
        v.ex = 10'(x); v.ey = 10'(y); v.esq = 4'(sq);
        v.ebusy = b; v.eland = l; v.edist = 10'(d);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int y, input int sq,
                           input logic b, input logic l, input int d);
        chk({tag, ".x"},    16'(o_x_man),       16'(x));
        chk({tag, ".y"},    16'(o_y_man),       16'(y));
        chk({tag, ".sq"},   16'(o_squeeze_man), 16'(sq));
        chk({tag, ".busy"}, 16'(o_busy),        16'(b));
        chk({tag, ".land"}, 16'(o_landed),      16'(l));
        chk({tag, ".dist"}, 16'(o_jump_dist),   16'(d));
    endtask

    task automatic cyc(input logic tk);
        i_tick = tk;
        @(posedge clk);
        #1;
        i_tick = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            i_press     = vecs[r].press;
            i_en        = vecs[r].en;
            i_reset_pos = vecs[r].rpos;
            cyc(1'b0);
            i_reset_pos = 1'b0;
            repeat (vecs[r].ticks) cyc(1'b1);
            chk_all($sformatf("row%0d", r), int'(vecs[r].ex), int'(vecs[r].ey),
                    int'(vecs[r].esq), vecs[r].ebusy, vecs[r].eland, int'(vecs[r].edist));
            $display("row %0d: press=%0b en=%0b rpos=%0b ticks=%0d -> x=%0d y=%0d sq=%0d busy=%0b land=%0b dist=%0d",
                     r, vecs[r].press, vecs[r].en, vecs[r].rpos, vecs[r].ticks,
                     o_x_man, o_y_man, o_squeeze_man, o_busy, o_landed, o_jump_dist);
        end
    endtask

    function automatic int model_x(input int x0, input int d, input int t);
        int x;
        x = x0 + (d * t) / 32;
        return (x > 639) ? 639 : x;
    endfunction

    function automatic int model_y(input int t);
        return 400 - (t * (32 - t)) / 4;
    endfunction

    initial begin
        //              p  en r  ticks  x    y   sq b  l  dist
        vecs[0]  = mk(1, 1, 0, 20,   40, 400,  5, 1, 0,   0);
        vecs[1]  = mk(0, 1, 0, 0,    40, 400,  0, 1, 0,  80);
        vecs[2]  = mk(1, 1, 0, 16,   80, 336,  0, 1, 0,  80);
        vecs[3]  = mk(1, 1, 0, 16,  120, 400,  0, 0, 1,  80);
        vecs[4]  = mk(1, 1, 0, 5,   120, 400,  0, 0, 0,  80);
        vecs[5]  = mk(0, 1, 0, 0,   120, 400,  0, 0, 0,  80);
        vecs[6]  = mk(1, 1, 0, 100, 120, 400, 15, 1, 0,  80);
        vecs[7]  = mk(0, 1, 0, 0,   120, 400,  0, 1, 0, 252);
        vecs[8]  = mk(0, 1, 0, 32,  372, 400,  0, 0, 1, 252);
        vecs[9]  = mk(0, 1, 0, 0,   372, 400,  0, 0, 0, 252);
        vecs[10] = mk(1, 1, 0, 100, 372, 400, 15, 1, 0, 252);
        vecs[11] = mk(0, 1, 0, 0,   372, 400,  0, 1, 0, 252);
        vecs[12] = mk(0, 1, 0, 32,  624, 400,  0, 0, 1, 252);
        vecs[13] = mk(0, 1, 0, 0,   624, 400,  0, 0, 0, 252);
        vecs[14] = mk(1, 1, 0, 100, 624, 400, 15, 1, 0, 252);
        vecs[15] = mk(0, 1, 0, 0,   624, 400,  0, 1, 0, 252);
        vecs[16] = mk(1, 1, 0, 0,   639, 400,  0, 1, 0, 252);
        vecs[17] = mk(0, 1, 0, 0,   639, 400,  0, 0, 0, 252);
        vecs[18] = mk(0, 1, 1, 0,    40, 400,  0, 0, 0, 252);
        vecs[19] = mk(1, 1, 0, 10,   40, 400,  2, 1, 0, 252);
        vecs[20] = mk(0, 1, 0, 0,    40, 400,  0, 1, 0,  40);
        vecs[21] = mk(0, 1, 0, 10,   52, 345,  0, 1, 0,  40);
        vecs[22] = mk(0, 0, 0, 0,    52, 400,  0, 0, 0,  40);
        vecs[23] = mk(0, 1, 0, 3,    52, 400,  0, 0, 0,  40);

        rst_n = 1'b0; i_tick = 1'b0; i_en = 1'b1; i_press = 1'b0; i_reset_pos = 1'b0;
        #13;
        chk_all("reset", 40, 400, 0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1'b0);

        // Basic charge, launch, mid-flight, landing, saturated charges.
        run_rows(0, 15);

        // Saturated flight from x0 = 624: follow every tick, never past 639.
        i_press = 1'b0;
        for (int t = 1; t <= 32; t++) begin
            cyc(1'b1);
            chk($sformatf("sat_t%0d.x", t), 16'(o_x_man), 16'(model_x(624, 252, t)));
            chk($sformatf("sat_t%0d.y", t), 16'(o_y_man), 16'(model_y(t)));
            chk($sformatf("sat_t%0d.land", t), 16'(o_landed), 16'(t == 32));
            chk($sformatf("sat_t%0d.busy", t), 16'(o_busy), 16'(t != 32));
            $display("sat t=%0d: x=%0d y=%0d land=%0b", t, o_x_man, o_y_man, o_landed);
        end
        cyc(1'b0);
        chk("sat_after.land", 16'(o_landed), 16'd0);
        chk("sat_after.x", 16'(o_x_man), 16'd639);

        // Zero-charge release, reset_pos, disable abort at t = 10.
        run_rows(16, 23);

        // Release coincident with a tick: tick not counted (8 charge, not 9).
        i_press = 1'b1;
        cyc(1'b0);
        repeat (8) cyc(1'b1);
        chk("coinc.sq", 16'(o_squeeze_man), 16'd2);
        i_press = 1'b0;
        cyc(1'b1);
        chk("coinc.dist", 16'(o_jump_dist), 16'd32);
        chk("coinc.busy", 16'(o_busy), 16'd1);
        chk("coinc.x", 16'(o_x_man), 16'd52);
        $display("coinc: dist=%0d busy=%0b x=%0d", o_jump_dist, o_busy, o_x_man);
        repeat (5) cyc(1'b1);
        chk_all("coinc_t5", 57, 367, 0, 1'b1, 1'b0, 32);

        // Asynchronous reset mid-flight: outputs return without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 40, 400, 0, 1'b0, 1'b0, 0);
        $display("async reset: x=%0d y=%0d busy=%0b dist=%0d", o_x_man, o_y_man, o_busy, o_jump_dist);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) cyc(1'b1);
        chk_all("post_rst", 40, 400, 0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/man_jump_ctrl.md
Name: man_jump_ctrl

Overview:
- Game-logic stage directly upstream of `graphics`. Converts the player button into the man sprite state: squeeze level while charging, then a parabolic jump trajectory.
- Drives the `i_x_man`, `i_y_man` and `i_squeeze_man` inputs of `graphics`.
- Advances once per frame tick (one-cycle pulse derived from the VGA frame/`clkdiv`), so motion is frame-locked.
- Reports landing so downstream scoring/block logic can judge the jump.

Parameters:
- X_START, 10'd40, man x after reset / `i_reset_pos`
- Y_GROUND, 10'd400, man y when standing
- X_MAX, 10'd639, x saturation limit
- CHARGE_MAX, 6'd63, charge counter saturation value
- DIST_GAIN, 3'd4, pixels of jump distance per charge unit
- LOG_T, 5, flight length is 2^LOG_T ticks (32)
- HSHIFT, 2, right shift applied to t*(T-t) to form jump height

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_tick  in  1  one-cycle frame-advance pulse
- i_en  in  1  game running (low during title/gameover)
- i_press  in  1  debounced button level, high = pressed
- i_reset_pos  in  1  one-cycle pulse: return man to X_START (only honoured in IDLE)
- o_x_man  out  10  man x, to graphics
- o_y_man  out  10  man y, to graphics
- o_squeeze_man  out  4  squeeze level, to graphics
- o_busy  out  1  high in CHARGE or FLIGHT
- o_landed  out  1  one-cycle pulse on landing
- o_jump_dist  out  10  distance of the last launched jump

Behaviour:
- Reset values (async on rst_n low):
  - state = IDLE
  - o_x_man = X_START, o_y_man = Y_GROUND
  - o_squeeze_man = 0, o_busy = 0, o_landed = 0, o_jump_dist = 0
  - charge = 0, t = 0, press_prev = 0, armed = 1
- All outputs are registered. Reaction to a tick appears one clk after the tick cycle.
- Press edge: rise = i_press & ~press_prev, sampled every clk.
  - armed is cleared at launch.
  - armed is set when i_press is seen low in IDLE.
- IDLE → CHARGE: on rise with armed = 1, charge := 0.
- CHARGE:
  - Each tick while i_press = 1: charge := min(charge + 1, CHARGE_MAX).
  - o_squeeze_man = charge >> 2, saturating at 15.
- CHARGE → FLIGHT: on i_press = 0 with charge ≠ 0.
  - dist := min(charge * DIST_GAIN, 10 bits).
  - x0 := o_x_man, t := 0.
  - o_jump_dist := dist, o_squeeze_man := 0.
- CHARGE → IDLE: on i_press = 0 with charge = 0. No jump; squeeze returns to 0.
- FLIGHT: each tick, t := t + 1. For t in 1..T (T = 2^LOG_T):
  - o_x_man = min(x0 + ((dist * t) >> LOG_T), X_MAX)
  - o_y_man = Y_GROUND − ((t * (T − t)) >> HSHIFT)
  - Intermediate width is 16 bits; no overflow for legal parameters.
  - i_press is ignored.
- FLIGHT → IDLE: on the tick where t reaches T.
  - o_y_man = Y_GROUND, o_x_man is final.
  - o_landed = 1 for exactly one clk.
- i_reset_pos:
  - In IDLE: o_x_man := X_START.
  - In other states: ignored.
- i_en = 0 (any state): next clk
  - state = IDLE, charge = 0, t = 0
  - o_squeeze_man = 0, o_y_man = Y_GROUND
  - o_x_man holds, no o_landed pulse, armed cleared.
  - i_en has priority over tick and press in the same cycle.
- Release and tick in the same cycle in CHARGE: the release wins and the tick is not counted.
- i_tick with no state-relevant activity: no output change.

Decomposition:
- Shared header `game_defs.vh`: state encodings (IDLE, CHARGE, FLIGHT), screen constants (640x480, X_MAX), Y_GROUND default. `graphics`-side logic reuses the same constants.
- One natural sub-module, `jump_traj`: combinational. Takes (x0, dist, t) and produces (x, y) using the clamp and parabola above, so it can be unit-tested in isolation.
- The FSM, counters and edge logic stay in `man_jump_ctrl`.

Test Plan:
- Basic charge: reset; press held for 20 ticks → charge 20, o_squeeze_man = 5, o_busy = 1, o_x_man = 40, o_y_man = 400.
- Launch and mid-flight: release after the 20-tick charge → o_jump_dist = 80, o_squeeze_man = 0. At t = 16: o_x_man = 80, o_y_man = 336.
- Landing: at t = 32 → o_x_man = 120, o_y_man = 400, o_landed high for one clk, o_busy = 0. Button held through the whole flight → no new charge until release then re-press.
- Saturation: press held for 100 ticks → charge 63, squeeze 15, dist 252. From x0 = 600, landing x = 639, never exceeding 639 at any t.
- Zero-charge release: press and release with no tick in between → back to IDLE, no o_landed, position unchanged.
- Aborts:
  - i_en low at t = 10 → next clk IDLE, y = 400, x held, no o_landed.
  - rst_n low mid-flight → immediate x = 40, y = 400, all outputs at reset values.
